// File: rtl/demux_reg_pkg.sv
// Shared constants for the registered 1-to-2 demultiplexer.
package demux_reg_pkg;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/demux_reg_hold_slot.sv
// One-entry valid/data holding register with a wrapping delivered-word counter.
module hold_slot #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          drain,
  input  logic [N-1:0]  din,
  output logic          valid,
  output logic [N-1:0]  dout,
  output logic [CW-1:0] count
);
  logic          valid_q, valid_d;
  logic [N-1:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hs;

  // drain is the consumer's ready; it only counts while a word is held
  always_comb begin
    hs      = valid_q & drain;
    valid_d = load | (valid_q & ~hs);
    data_d  = load ? din : data_q;
    cnt_d   = hs ? cnt_q + CW'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;
  assign count = cnt_q;
endmodule

// File: rtl/demux_reg.sv
// Registered one-to-two demultiplexer: steers each input word into slot A or B.
module demux_reg
  import demux_reg_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sel,
  input  logic [N-1:0]  in_data,
  output logic          a_valid,
  input  logic          a_ready,
  output logic [N-1:0]  a_data,
  output logic          b_valid,
  input  logic          b_ready,
  output logic [N-1:0]  b_data,
  output logic [CW-1:0] a_count,
  output logic [CW-1:0] b_count
);
  logic accept;
  logic load_a, load_b;

  // Only the selected slot gates acceptance; a full slot draining this cycle can refill.
  always_comb begin
    in_ready = (in_sel == SEL_B) ? (~b_valid | b_ready) : (~a_valid | a_ready);
    accept   = in_valid & in_ready;
    load_a   = accept & (in_sel == SEL_A);
    load_b   = accept & (in_sel == SEL_B);
  end

  hold_slot #(.N(N), .CW(CW)) u_slot_a (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_a),
    .drain (a_ready),
    .din   (in_data),
    .valid (a_valid),
    .dout  (a_data),
    .count (a_count)
  );

  hold_slot #(.N(N), .CW(CW)) u_slot_b (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_b),
    .drain (b_ready),
    .din   (in_data),
    .valid (b_valid),
    .dout  (b_data),
    .count (b_count)
  );
endmodule

// File: tb/tb_demux_reg.sv
// Directed bench for demux_reg with a 2-bit counter so wrap-around is reachable.
module tb_demux_reg;
  localparam int N  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_sel;
  logic [N-1:0]  in_data;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic [N-1:0]  a_data, b_data;
  logic [CW-1:0] a_count, b_count;

  int n_total = 0;
  int n_pass  = 0;

  demux_reg #(.N(N), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    a_ready = 1'b0; b_ready = 1'b0;
    step();

    // Reset state
    in_valid = 1'b1;
    #1;
    check("rst_a_valid", 32'(a_valid), 0);
    check("rst_b_valid", 32'(b_valid), 0);
    check("rst_a_data",  32'(a_data), 0);
    check("rst_b_data",  32'(b_data), 0);
    check("rst_a_count", 32'(a_count), 0);
    check("rst_b_count", 32'(b_count), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;

    // Single word into A, back-pressured
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h5; a_ready = 1'b0;
    step();
    check("load_a_valid", 32'(a_valid), 1);
    check("load_a_data",  32'(a_data), 5);
    check("load_b_valid", 32'(b_valid), 0);
    in_sel = 1'b0; #1;
    check("rdy_sel_a_full", 32'(in_ready), 0);
    in_sel = 1'b1; #1;
    check("rdy_sel_b_empty", 32'(in_ready), 1);

    // Drain and refill A in the same cycle
    in_sel = 1'b0; in_data = 4'h9; a_ready = 1'b1; #1;
    check("refill_in_ready", 32'(in_ready), 1);
    step();
    check("refill_a_valid", 32'(a_valid), 1);
    check("refill_a_data",  32'(a_data), 9);
    check("refill_a_count", 32'(a_count), 1);
    in_valid = 1'b0;
    step();
    check("drain_a_valid", 32'(a_valid), 0);
    check("drain_a_data_held", 32'(a_data), 9);
    check("drain_a_count", 32'(a_count), 2);
    a_ready = 1'b0;

    // Alternating select, both consumers ready
    do_reset();
    a_ready = 1'b1; b_ready = 1'b1; in_valid = 1'b1;
    in_sel = 1'b0; in_data = 4'h1;
    step();
    check("alt1_a_valid", 32'(a_valid), 1);
    check("alt1_a_data",  32'(a_data), 1);
    check("alt1_b_valid", 32'(b_valid), 0);
    in_sel = 1'b1; in_data = 4'h2;
    step();
    check("alt2_a_valid", 32'(a_valid), 0);
    check("alt2_a_count", 32'(a_count), 1);
    check("alt2_b_valid", 32'(b_valid), 1);
    check("alt2_b_data",  32'(b_data), 2);
    in_sel = 1'b0; in_data = 4'h3;
    step();
    check("alt3_a_data",  32'(a_data), 3);
    check("alt3_a_valid", 32'(a_valid), 1);
    check("alt3_b_valid", 32'(b_valid), 0);
    check("alt3_b_count", 32'(b_count), 1);
    in_sel = 1'b1; in_data = 4'h4;
    step();
    check("alt4_b_data",  32'(b_data), 4);
    check("alt4_b_valid", 32'(b_valid), 1);
    check("alt4_a_count", 32'(a_count), 2);
    in_valid = 1'b0;
    step();
    check("alt5_b_count", 32'(b_count), 2);
    check("alt5_a_count", 32'(a_count), 2);
    check("alt5_b_valid", 32'(b_valid), 0);

    // B back-pressured while A streams
    do_reset();
    a_ready = 1'b1; b_ready = 1'b0; in_valid = 1'b1;
    in_sel = 1'b1; in_data = 4'hC;
    step();
    check("bp_load_b_data", 32'(b_data), 4'hC);
    in_sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = 4'(i + 1);
      step();
      check("bp_b_valid", 32'(b_valid), 1);
      check("bp_b_data",  32'(b_data), 4'hC);
      check("bp_b_count", 32'(b_count), 0);
      check("bp_a_data",  32'(a_data), 32'(i + 1));
      check("bp_a_count", 32'(a_count), 32'(i % 4));
    end
    in_valid = 1'b0; b_ready = 1'b1;
    step();
    check("bp_rel_b_count", 32'(b_count), 1);
    check("bp_rel_b_valid", 32'(b_valid), 0);
    check("bp_rel_a_count", 32'(a_count), 1);
    step();
    check("bp_rel2_b_count", 32'(b_count), 1);
    b_ready = 1'b0;

    // Counter wrap with CW=2
    do_reset();
    a_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h5;
    step();
    check("wrap_first_count", 32'(a_count), 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("wrap_a_count", 32'(a_count), 32'(k % 4));
    end

    // Asynchronous reset mid-cycle with both slots full
    a_ready = 1'b0; in_sel = 1'b1; in_data = 4'hB;
    step();
    in_valid = 1'b0;
    check("pre_arst_a_valid", 32'(a_valid), 1);
    check("pre_arst_b_data",  32'(b_data), 4'hB);
    check("pre_arst_a_count", 32'(a_count), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_a_valid", 32'(a_valid), 0);
    check("arst_b_valid", 32'(b_valid), 0);
    check("arst_a_data",  32'(a_data), 0);
    check("arst_b_data",  32'(b_data), 0);
    check("arst_a_count", 32'(a_count), 0);
    #2 rst_n = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h7;
    step();
    check("post_arst_a_valid", 32'(a_valid), 1);
    check("post_arst_a_data",  32'(a_data), 7);
    check("post_arst_b_valid", 32'(b_valid), 0);
    in_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
